// File: rtl/mp_regfile_pkg.sv
// rtl/mp_regfile_pkg.sv - shared sizes, types and FSM states for the multi-ported register file
package regfile_pkg;

    localparam int NREAD  = 8;
    localparam int NWRITE = 4;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 2 ** AW;
    localparam int LANE_W = $clog2(NWRITE);

    typedef logic [AW-1:0] regaddr_t;
    typedef logic [DW-1:0] regdata_t;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

    localparam regaddr_t RF_ZERO_IDX = '0;

endpackage

// File: rtl/mp_regfile_if.sv
// rtl/mp_regfile_if.sv - write lanes, read ports and status of the register file
interface mp_regfile_if
    import regfile_pkg::*;
();

    logic     [NWRITE-1:0] we;
    regaddr_t [NWRITE-1:0] waddr;
    regdata_t [NWRITE-1:0] wdata;
    regaddr_t [NREAD-1:0]  raddr;
    regdata_t [NREAD-1:0]  rdata;
    logic                  init_done;
    logic                  wcollide;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, init_done, wcollide
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, init_done, wcollide
    );

endinterface

// File: rtl/mp_regfile_lane_sel.sv
// rtl/mp_regfile_lane_sel.sv - finds whether any enabled write lane targets an address, youngest lane wins
module rf_lane_sel
    import regfile_pkg::*;
(
    input  logic     [NWRITE-1:0] i_we,
    input  regaddr_t [NWRITE-1:0] i_waddr,
    input  regaddr_t              i_target,
    output logic                  o_hit,
    output logic     [LANE_W-1:0] o_lane
);

    // Ascending scan so a later (younger) lane overrides an earlier match.
    always_comb begin
        o_hit  = 1'b0;
        o_lane = '0;
        for (int i = 0; i < NWRITE; i++) begin
            if (i_we[i] && (i_waddr[i] == i_target)) begin
                o_hit  = 1'b1;
                o_lane = LANE_W'(i);
            end
        end
    end

endmodule

// File: rtl/mp_regfile.sv
// rtl/mp_regfile.sv - multi-ported register file with post-reset clear sweep; optional REGFILE_BYPASS_EN forwarding
module mp_regfile
    import regfile_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mp_regfile_if.slave  rf
);

    rf_state_e          r_state;
    rf_state_e          w_state_nxt;
    regaddr_t           r_clr_ptr;
    logic               r_wcollide;
    logic               w_ready;
    logic               w_collide;
    logic  [NWRITE-1:0] w_we;
    regdata_t           w_row [DEPTH];
    regdata_t           w_rd  [NREAD];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RF_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == RF_INIT && r_clr_ptr == regaddr_t'(DEPTH - 1))
            w_state_nxt = RF_READY;
    end

    // Writes are suppressed until the sweep has finished.
    always_comb begin
        w_ready = (r_state == RF_READY);
        w_we    = w_ready ? rf.we : '0;
    end

    assign rf.init_done = w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_clr_ptr <= '0;
        else if (r_state == RF_INIT) r_clr_ptr <= r_clr_ptr + regaddr_t'(1);
    end

    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < NWRITE; i++)
            for (int j = i + 1; j < NWRITE; j++)
                if (w_we[i] && w_we[j] && (rf.waddr[i] == rf.waddr[j]) &&
                    (rf.waddr[i] != RF_ZERO_IDX))
                    w_collide = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wcollide <= 1'b0;
        else       r_wcollide <= w_collide;
    end

    assign rf.wcollide = r_wcollide;

    // Storage rows carry no reset; the sweep clears them one per cycle.
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        if (regaddr_t'(r) == RF_ZERO_IDX) begin : g_zero
            assign w_row[r] = '0;
        end else begin : g_store
            logic              w_hit;
            logic [LANE_W-1:0] w_lane;
            regdata_t          r_data;

            rf_lane_sel u_sel (
                .i_we    (w_we),
                .i_waddr (rf.waddr),
                .i_target(regaddr_t'(r)),
                .o_hit   (w_hit),
                .o_lane  (w_lane)
            );

            always_ff @(posedge clk) begin
                if (!w_ready && r_clr_ptr == regaddr_t'(r)) r_data <= '0;
                else if (w_hit)                             r_data <= rf.wdata[w_lane];
            end

            assign w_row[r] = r_data;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
        logic              w_bhit;
        logic [LANE_W-1:0] w_blane;

        rf_lane_sel u_byp (
            .i_we    (w_we),
            .i_waddr (rf.waddr),
            .i_target(rf.raddr[p]),
            .o_hit   (w_bhit),
            .o_lane  (w_blane)
        );

        assign w_rd[p] = (!w_ready || rf.raddr[p] == RF_ZERO_IDX) ? '0 :
                         w_bhit ? rf.wdata[w_blane] : w_row[rf.raddr[p]];
`else
        assign w_rd[p] = (!w_ready || rf.raddr[p] == RF_ZERO_IDX) ? '0 :
                         w_row[rf.raddr[p]];
`endif
    end

    always_comb begin
        rf.rdata = '0;
        for (int p = 0; p < NREAD; p++) rf.rdata[p] = w_rd[p];
    end

endmodule

// File: tb/tb_mp_regfile.sv
// tb/tb_mp_regfile.sv - directed self-checking bench for mp_regfile
module tb_mp_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cycles;
    logic saw_collide;

    mp_regfile_if rf ();

    mp_regfile dut (
        .clk  (clk),
        .reset(reset),
        .rf   (rf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rf.we = '0;
        for (int i = 0; i < NWRITE; i++) begin
            rf.waddr[i] = '0;
            rf.wdata[i] = '0;
        end
    endtask

    task automatic set_lane(input int l, input logic [4:0] a, input logic [31:0] d);
        rf.we[l]    = 1'b1;
        rf.waddr[l] = a;
        rf.wdata[l] = d;
    endtask

    task automatic set_reads(input logic [4:0] a);
        for (int p = 0; p < NREAD; p++) rf.raddr[p] = a;
    endtask

    // Counts sampled cycles with init_done low after reset release.
    task automatic count_sweep(output int n);
        n           = 0;
        saw_collide = 1'b0;
        while (!rf.init_done && n < 100) begin
            if (rf.wcollide) saw_collide = 1'b1;
            n++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_reads(5'd7);
        step();
        step();
        check("rst_init_done", {31'd0, rf.init_done}, 32'd0);
        check("rst_wcollide", {31'd0, rf.wcollide}, 32'd0);
        check("rst_rdata", rf.rdata[0], 32'd0);

        reset = 1'b0;
        count_sweep(cycles);
        check("sweep1_len", cycles, 32'd32);

        // Preload r7, then a reset sweep must clear it and ignore writes.
        set_lane(0, 5'd7, 32'hDEAD);
        step();
        idle();
        check("preload_r7", rf.rdata[0], 32'hDEAD);

        reset = 1'b1;
        #1;
        check("reset_drops_done", {31'd0, rf.init_done}, 32'd0);
        step();
        reset = 1'b0;
        set_lane(0, 5'd7, 32'hBEEF);
        set_lane(1, 5'd8, 32'h1234);
        set_lane(3, 5'd8, 32'h5678);
        count_sweep(cycles);
        idle();
        check("sweep2_len", cycles, 32'd32);
        check("sweep_no_collide", {31'd0, saw_collide}, 32'd0);
        check("sweep_r7_clear", rf.rdata[0], 32'd0);
        set_reads(5'd8);
        #1;
        check("sweep_r8_clear", rf.rdata[0], 32'd0);

        // Four lanes, four distinct registers.
        set_lane(0, 5'd1, 32'h11);
        set_lane(1, 5'd2, 32'h22);
        set_lane(2, 5'd3, 32'h33);
        set_lane(3, 5'd4, 32'h44);
        step();
        idle();
        for (int p = 0; p < NREAD; p++) rf.raddr[p] = 5'((p % 4) + 1);
        #1;
        for (int p = 0; p < NREAD; p++)
            check($sformatf("quad_rd%0d", p), rf.rdata[p], 32'h11 * ((p % 4) + 1));
        check("quad_wcollide", {31'd0, rf.wcollide}, 32'd0);

        // Lanes 0, 2, 3 collide on r5: lane 3 wins.
        set_lane(0, 5'd5, 32'hA);
        set_lane(2, 5'd5, 32'hB);
        set_lane(3, 5'd5, 32'hC);
        step();
        idle();
        set_reads(5'd5);
        #1;
        check("collide_r5", rf.rdata[2], 32'hC);
        check("collide_pulse", {31'd0, rf.wcollide}, 32'd1);
        step();
        check("collide_pulse_end", {31'd0, rf.wcollide}, 32'd0);

        // Writes to r0 are dropped and never count as collisions.
        set_lane(1, 5'd0, 32'hFFFF_FFFF);
        step();
        idle();
        set_reads(5'd0);
        #1;
        check("r0_single", rf.rdata[0], 32'd0);
        check("r0_single_coll", {31'd0, rf.wcollide}, 32'd0);
        set_lane(0, 5'd0, 32'h1);
        set_lane(1, 5'd0, 32'h2);
        step();
        idle();
        check("r0_pair", rf.rdata[1], 32'd0);
        check("r0_pair_coll", {31'd0, rf.wcollide}, 32'd0);

        // Same-cycle read of a register being written.
        set_lane(0, 5'd9, 32'h99);
        step();
        idle();
        set_reads(5'd9);
        set_lane(2, 5'd9, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", rf.rdata[3], 32'h55);
`else
        check("bypass_same", rf.rdata[3], 32'h99);
`endif
        step();
        idle();
        check("bypass_next", rf.rdata[3], 32'h55);

        // Reset mid-sweep restarts the full sweep.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        #1;
        check("mid_reset_done", {31'd0, rf.init_done}, 32'd0);
        step();
        reset = 1'b0;
        count_sweep(cycles);
        check("sweep3_len", cycles, 32'd32);
        for (int a = 1; a < DEPTH; a++) begin
            rf.raddr[a % NREAD] = 5'(a);
            #1;
            check($sformatf("clear_r%0d", a), rf.rdata[a % NREAD], 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
